// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared JK op encoding and sequencer FSM state constants
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_op_e;

  typedef logic [0:0] jk_state_t;
  localparam jk_state_t IDLE  = 1'b0;
  localparam jk_state_t DRIVE = 1'b1;

endpackage

// File: rtl/jk_cmd_fifo.sv
// rtl/jk_cmd_fifo.sv - synchronous command FIFO with wrap-bit pointers
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // Top bit of each pointer is the wrap bit that separates full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// rtl/jk_cmd_sequencer.sv - replays queued JK ops on registered J/K; optional Q checker under JK_CMD_SEQUENCER_CHECK_EN
module jk_cmd_sequencer
  import jk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             J,
  output logic             K,
  output logic             busy,
  input  logic             q_in,
  output logic             mismatch
);

  localparam int W = 2 + CNT_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [W-1:0]     head;
  logic [1:0]       head_op;
  logic [CNT_W-1:0] head_cnt;
  logic [CNT_W-1:0] remaining;
  jk_state_t        state;

  assign cmd_ready = !full && rst_n;
  assign push      = cmd_valid && cmd_ready;
  assign head_op   = head[W-1:CNT_W];
  assign head_cnt  = head[CNT_W-1:0];
  assign busy      = (state == DRIVE) || !empty;

  // Pop on the edge that loads J/K so back-to-back commands leave no gap.
  assign pop = !empty && ((state == IDLE) || (remaining == '0));

  jk_cmd_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(W)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .wdata({cmd_op, cmd_cnt}),
    .pop  (pop),
    .full (full),
    .empty(empty),
    .head (head)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      J         <= 1'b0;
      K         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            {J, K}    <= head_op;
            remaining <= head_cnt;
            state     <= DRIVE;
          end else begin
            {J, K} <= 2'b00;
          end
        end
        default: begin
          if (remaining != '0) begin
            remaining <= remaining - CNT_ONE;
          end else if (!empty) begin
            {J, K}    <= head_op;
            remaining <= head_cnt;
          end else begin
            {J, K} <= 2'b00;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef JK_CMD_SEQUENCER_CHECK_EN
  logic q_exp;
  logic exp_valid;

  // The model only becomes trustworthy after the first set or reset fixes Q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_exp     <= 1'b0;
      exp_valid <= 1'b0;
      mismatch  <= 1'b0;
    end else begin
      if (exp_valid && (q_in != q_exp)) begin
        mismatch <= 1'b1;
      end
      case ({J, K})
        JK_RESET:  q_exp <= 1'b0;
        JK_SET:    q_exp <= 1'b1;
        JK_TOGGLE: q_exp <= ~q_exp;
        default:   q_exp <= q_exp;
      endcase
      if (J ^ K) begin
        exp_valid <= 1'b1;
      end
    end
  end
`else
  logic unused_q_in;
  assign unused_q_in = q_in;
  assign mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb/tb_jk_cmd_sequencer.sv - self-checking bench for jk_cmd_sequencer
module tb_jk_cmd_sequencer;

`ifdef JK_CMD_SEQUENCER_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_cnt = 4'd0;
  logic       J;
  logic       K;
  logic       busy;
  logic       q_in;
  logic       mismatch;
  logic       q_ff = 1'b0;
  logic       force_q = 1'b0;
  logic       mon_en = 1'b0;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int last_end = 0;

  typedef struct {
    int   lbl;
    logic j;
    logic k;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0] op;
    logic [3:0] cnt;
    logic       ej;
    logic       ek;
    int         ncyc;
  } vec_t;
  vec_t tbl[8];

  jk_cmd_sequencer #(.DEPTH(4), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_cnt  (cmd_cnt),
    .J        (J),
    .K        (K),
    .busy     (busy),
    .q_in     (q_in),
    .mismatch (mismatch)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!rst_n) q_ff <= 1'b0;
    else begin
      case ({J, K})
        2'b01:   q_ff <= 1'b0;
        2'b10:   q_ff <= 1'b1;
        2'b11:   q_ff <= ~q_ff;
        default: q_ff <= q_ff;
      endcase
    end
  end

  assign q_in = force_q ? 1'b0 : q_ff;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Output labelled by the edge count that produced it; idle cycles must read 00.
  always @(negedge clk) begin
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].lbl < cyc) begin
        check("missed_slot", 32'(cyc), 32'(sb[0].lbl));
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].lbl == cyc) begin
        check("drive_J", J, sb[0].j);
        check("drive_K", K, sb[0].k);
        check("drive_busy", busy, 1);
        void'(sb.pop_front());
      end else begin
        check("idle_J", J, 0);
        check("idle_K", K, 0);
      end
    end
  end

  task automatic push_cmd(input logic [1:0] op, input logic [3:0] cnt,
                          input logic ej, input logic ek, input int ncyc,
                          output int plbl);
    logic acc;
    int   waitc;
    int   s;
    acc = 1'b0;
    waitc = 0;
    plbl = -1;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_cnt = cnt;
    while (!acc && waitc < 100) begin
      acc = cmd_ready;
      @(posedge clk);
      #1;
      waitc++;
    end
    cmd_valid = 1'b0;
    check("accepted", acc, 1);
    if (acc) begin
      plbl = cyc;
      s = (plbl + 1 > last_end + 1) ? plbl + 1 : last_end + 1;
      for (int i = 0; i < ncyc; i++) begin
        sb.push_back('{lbl: s + i, j: ej, k: ek});
      end
      last_end = s + ncyc - 1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 32'(sb.size()), 0);
    @(negedge clk);
    check("busy_after_drain", busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    last_end = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int pa;
    tbl[0] = '{op: 2'b10, cnt: 4'd2,  ej: 1'b1, ek: 1'b0, ncyc: 3};
    tbl[1] = '{op: 2'b01, cnt: 4'd7,  ej: 1'b0, ek: 1'b1, ncyc: 8};
    tbl[2] = '{op: 2'b10, cnt: 4'd1,  ej: 1'b1, ek: 1'b0, ncyc: 2};
    tbl[3] = '{op: 2'b00, cnt: 4'd2,  ej: 1'b0, ek: 1'b0, ncyc: 3};
    tbl[4] = '{op: 2'b11, cnt: 4'd0,  ej: 1'b1, ek: 1'b1, ncyc: 1};
    tbl[5] = '{op: 2'b01, cnt: 4'd3,  ej: 1'b0, ek: 1'b1, ncyc: 4};
    tbl[6] = '{op: 2'b10, cnt: 4'd0,  ej: 1'b1, ek: 1'b0, ncyc: 1};
    tbl[7] = '{op: 2'b11, cnt: 4'd15, ej: 1'b1, ek: 1'b1, ncyc: 16};

    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 0);
    check("rst_J", J, 0);
    check("rst_K", K, 0);
    check("rst_busy", busy, 0);
    check("rst_mismatch", mismatch, 0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", cmd_ready, 1);
    mon_en = 1'b1;
    @(negedge clk);

    // Single set held for three cycles.
    push_cmd(tbl[0].op, tbl[0].cnt, tbl[0].ej, tbl[0].ek, tbl[0].ncyc, p);
    drain();

    // Back-to-back: long first command, then fill the FIFO behind it.
    push_cmd(tbl[1].op, tbl[1].cnt, tbl[1].ej, tbl[1].ek, tbl[1].ncyc, pa);
    for (int i = 2; i <= 5; i++) begin
      push_cmd(tbl[i].op, tbl[i].cnt, tbl[i].ej, tbl[i].ek, tbl[i].ncyc, p);
    end
    check("ready_low_at_full", cmd_ready, 0);
    check("busy_while_full", busy, 1);
    push_cmd(tbl[6].op, tbl[6].cnt, tbl[6].ej, tbl[6].ek, tbl[6].ncyc, p);
    check("blocked_push_edge", 32'(p), 32'(pa + 10));
    drain();

    // Longest count: sixteen toggle cycles, no wrap.
    push_cmd(tbl[7].op, tbl[7].cnt, tbl[7].ej, tbl[7].ek, tbl[7].ncyc, p);
    drain();

    // Reset in the middle of a command with two entries queued.
    push_cmd(2'b10, 4'd9, 1'b1, 1'b0, 10, p);
    push_cmd(2'b01, 4'd3, 1'b0, 1'b1, 4, p);
    push_cmd(2'b11, 4'd3, 1'b1, 1'b1, 4, p);
    repeat (2) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    do_reset();
    @(negedge clk);
    check("midrst_J", J, 0);
    check("midrst_K", K, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", cmd_ready, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_busy", busy, 0);

    // Checker: set, toggle x3, reset against the bench flip-flop.
    push_cmd(2'b10, 4'd0, 1'b1, 1'b0, 1, p);
    push_cmd(2'b11, 4'd2, 1'b1, 1'b1, 3, p);
    push_cmd(2'b01, 4'd0, 1'b0, 1'b1, 1, p);
    drain();
    check("chk_clean_seq", mismatch, 0);
    push_cmd(2'b10, 4'd0, 1'b1, 1'b0, 1, p);
    drain();
    check("chk_before_force", mismatch, 0);
    force_q = 1'b1;
    @(negedge clk);
    check("chk_after_force", mismatch, CHK);
    force_q = 1'b0;
    repeat (5) @(negedge clk);
    check("chk_sticky", mismatch, CHK);
    do_reset();
    @(negedge clk);
    check("chk_cleared_by_rst", mismatch, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
